// File: rtl/product_accumulator.sv
// Burst accumulator: sums a length-prefixed run of unsigned products from an
// upstream multiplier and hands the total downstream with a valid/ready handshake.
module product_accumulator #(
    parameter int BITWIDTH = 8,
    parameter int CNTWIDTH = 8
) (
    input  logic                               iClk,
    input  logic                               iRst,
    input  logic                               iClr,
    input  logic                               iStart,
    input  logic [CNTWIDTH-1:0]                iLen,
    input  logic                               iValid,
    input  logic [2*BITWIDTH-1:0]              iProd,
    output logic                               oReady,
    output logic [2*BITWIDTH+CNTWIDTH-1:0]     oAcc,
    output logic                               oValid,
    input  logic                               iReady,
    output logic                               oBusy
);

    localparam int ACCWIDTH = 2*BITWIDTH + CNTWIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [ACCWIDTH-1:0]   r_sum;
    logic [CNTWIDTH-1:0]   r_cnt;
    logic [CNTWIDTH-1:0]   r_len;
    logic [ACCWIDTH-1:0]   r_acc;
    logic                  r_valid;

    logic                  w_last;
    logic [ACCWIDTH-1:0]   w_prod_ext;
    logic [ACCWIDTH-1:0]   w_sum_next;

    // Headroom of CNTWIDTH bits means the sum can never wrap, so no saturation.
    assign w_prod_ext = {{CNTWIDTH{1'b0}}, iProd};
    assign w_sum_next = r_sum + w_prod_ext;
    assign w_last     = (r_cnt == (r_len - CNTWIDTH'(1)));

    assign oReady = (r_state == ACC);
    assign oBusy  = (r_state != IDLE);
    assign oAcc   = r_acc;
    assign oValid = r_valid;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= IDLE;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_acc   <= '0;
            r_valid <= 1'b0;
        end else if (iClr) begin
            r_state <= IDLE;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_acc   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (iStart) begin
                        if (iLen != '0) begin
                            r_len   <= iLen;
                            r_sum   <= '0;
                            r_cnt   <= '0;
                            r_state <= ACC;
                        end else begin
                            // Empty burst: present a zero result straight away.
                            r_acc   <= '0;
                            r_valid <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                ACC: begin
                    if (iValid) begin
                        r_sum <= w_sum_next;
                        r_cnt <= r_cnt + CNTWIDTH'(1);
                        if (w_last) begin
                            r_acc   <= w_sum_next;
                            r_valid <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (iReady) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed table-driven bench for product_accumulator, plus hand sequences for
// the full-width burst and an asynchronous reset in the middle of a burst.
module tb_product_accumulator;

    localparam int BW = 8;
    localparam int CW = 8;
    localparam int AW = 2*BW + CW;

    logic            iClk = 1'b0;
    logic            iRst;
    logic            iClr;
    logic            iStart;
    logic [CW-1:0]   iLen;
    logic            iValid;
    logic [2*BW-1:0] iProd;
    logic            oReady;
    logic [AW-1:0]   oAcc;
    logic            oValid;
    logic            iReady;
    logic            oBusy;

    int n_vec = 0;
    int n_mis = 0;

    product_accumulator #(.BITWIDTH(BW), .CNTWIDTH(CW)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iClr   (iClr),
        .iStart (iStart),
        .iLen   (iLen),
        .iValid (iValid),
        .iProd  (iProd),
        .oReady (oReady),
        .oAcc   (oAcc),
        .oValid (oValid),
        .iReady (iReady),
        .oBusy  (oBusy)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic            clr;
        logic            start;
        logic [CW-1:0]   len;
        logic            valid;
        logic [2*BW-1:0] prod;
        logic            rdy;
        logic            e_valid;
        logic [AW-1:0]   e_acc;
        logic            e_ready;
        logic            e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic clr, input logic start, input int len,
                       input logic valid, input int prod, input logic rdy,
                       input logic ev, input int ea, input logic er, input logic eb);
        vec_t v;
        v.clr = clr;      v.start = start;  v.len = CW'(len);
        v.valid = valid;  v.prod = (2*BW)'(prod); v.rdy = rdy;
        v.e_valid = ev;   v.e_acc = AW'(ea); v.e_ready = er; v.e_busy = eb;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic ev, input logic [AW-1:0] ea,
                         input logic er, input logic eb);
        n_vec++;
        if (oValid !== ev || oAcc !== ea || oReady !== er || oBusy !== eb) begin
            n_mis++;
            $display("FAIL %s: got valid=%0b acc=%0d ready=%0b busy=%0b, want valid=%0b acc=%0d ready=%0b busy=%0b",
                     name, oValid, oAcc, oReady, oBusy, ev, ea, er, eb);
        end
    endtask

    task automatic drive(input logic clr, input logic start, input int len,
                         input logic valid, input int prod, input logic rdy);
        iClr = clr; iStart = start; iLen = CW'(len);
        iValid = valid; iProd = (2*BW)'(prod); iReady = rdy;
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        //   clr st  len vld prod rdy | valid acc     rdy busy
        // basic burst 10+20+30
        add(0, 1, 3,   0, 0,   1,   0, 0,   1, 1);
        add(0, 0, 0,   1, 10,  1,   0, 0,   1, 1);
        add(0, 0, 0,   1, 20,  1,   0, 0,   1, 1);
        add(0, 0, 0,   1, 30,  1,   1, 60,  0, 1);
        add(0, 0, 0,   0, 0,   1,   0, 60,  0, 0);
        // gaps and backpressure 100+200
        add(0, 1, 2,   0, 0,   0,   0, 60,  1, 1);
        add(0, 0, 0,   1, 100, 0,   0, 60,  1, 1);
        add(0, 0, 0,   0, 0,   0,   0, 60,  1, 1);
        add(0, 0, 0,   0, 0,   0,   0, 60,  1, 1);
        add(0, 0, 0,   1, 200, 0,   1, 300, 0, 1);
        add(0, 0, 0,   0, 0,   0,   1, 300, 0, 1);
        add(0, 0, 0,   0, 0,   0,   1, 300, 0, 1);
        add(0, 0, 0,   0, 0,   0,   1, 300, 0, 1);
        add(0, 0, 0,   0, 0,   1,   0, 300, 0, 0);
        // product in IDLE is dropped
        add(0, 0, 0,   1, 55,  0,   0, 300, 0, 0);
        // zero length, product offered alongside is never taken
        add(0, 1, 0,   1, 99,  0,   1, 0,   0, 1);
        // start/valid in DONE ignored; start on DONE exit ignored
        add(0, 1, 5,   1, 77,  0,   1, 0,   0, 1);
        add(0, 1, 5,   1, 77,  0,   1, 0,   0, 1);
        add(0, 1, 2,   1, 77,  1,   0, 0,   0, 0);
        add(0, 0, 0,   1, 4,   0,   0, 0,   0, 0);
        // clear mid-burst
        add(0, 1, 4,   0, 0,   0,   0, 0,   1, 1);
        add(0, 0, 0,   1, 5,   0,   0, 0,   1, 1);
        add(0, 0, 0,   1, 6,   0,   0, 0,   1, 1);
        add(1, 1, 3,   1, 9,   1,   0, 0,   0, 0);
        // clear wipes a held result
        add(0, 1, 1,   0, 0,   0,   0, 0,   1, 1);
        add(0, 0, 0,   1, 7,   0,   1, 7,   0, 1);
        add(1, 0, 0,   0, 0,   1,   0, 0,   0, 0);
        // clear beats the final accept
        add(0, 1, 1,   0, 0,   0,   0, 0,   1, 1);
        add(1, 0, 0,   1, 8,   0,   0, 0,   0, 0);

        drive(0, 0, 0, 0, 0, 0);
        iRst = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        check("reset_hold", 0, 0, 0, 0);
        #3 iRst = 1'b0;
        tick();
        check("after_reset", 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].clr, tbl[i].start, int'(tbl[i].len), tbl[i].valid,
                  int'(tbl[i].prod), tbl[i].rdy);
            tick();
            check($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_acc,
                  tbl[i].e_ready, tbl[i].e_busy);
        end

        // Full-width burst: 255 x 65025 = 16581375, no wrap
        drive(0, 1, 255, 0, 0, 0);
        tick();
        check("max_start", 0, 0, 1, 1);
        for (int k = 0; k < 255; k++) begin
            drive(0, 0, 0, 1, 65025, 0);
            tick();
            if (k == 253) check("max_penult", 0, 0, 1, 1);
        end
        check("max_result", 1, 24'd16581375, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        check("max_release", 0, 24'd16581375, 0, 0);

        // Asynchronous reset in the middle of a burst
        drive(0, 1, 4, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 11, 0);
        tick();
        tick();
        check("rst_pre", 0, 24'd16581375, 1, 1);
        #2 iRst = 1'b1;
        #1;
        check("rst_async", 0, 0, 0, 0);
        #2 iRst = 1'b0;
        drive(0, 0, 0, 1, 11, 1);
        tick();
        check("rst_no_partial1", 0, 0, 0, 0);
        tick();
        check("rst_no_partial2", 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        tick();
        check("post_rst_start", 0, 0, 1, 1);
        drive(0, 0, 0, 1, 7, 0);
        tick();
        check("post_rst_result", 1, 7, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        check("post_rst_release", 0, 7, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter BITWIDTH, default 8: operand width of the upstream multiplier; the product input is 2*BITWIDTH bits.
REQ-002 Parameter CNTWIDTH, default 8: width of the burst-length field.
REQ-003 Derived width ACCWIDTH = 2*BITWIDTH+CNTWIDTH; it is not overridable.
REQ-004 iClk  input  1  single clock; all state updates on its rising edge.
REQ-005 iRst  input  1  reset, asynchronous, active-high.
REQ-006 iClr  input  1  synchronous clear.
REQ-007 iStart  input  1  burst start request.
REQ-008 iLen  input  CNTWIDTH  number of products in the burst.
REQ-009 iValid  input  1  iProd is valid this cycle.
REQ-010 iProd  input  2*BITWIDTH  unsigned product from the registered multiplier.
REQ-011 oReady  output  1  block accepts iProd this cycle.
REQ-012 oAcc  output  ACCWIDTH  accumulated sum, registered.
REQ-013 oValid  output  1  oAcc holds a completed burst result.
REQ-014 iReady  input  1  downstream accepts oAcc.
REQ-015 oBusy  output  1  burst in progress or result pending.

Function
REQ-016 The FSM has three states: IDLE, ACC and DONE; oBusy is 1 in ACC and DONE.
REQ-017 In IDLE with iStart=1 and iLen>0: latch iLen, clear the sum and count, go to ACC.
REQ-018 In IDLE with iStart=1 and iLen=0: set oAcc=0 and go directly to DONE.
REQ-019 iStart outside IDLE is ignored; iLen is sampled only with an accepted iStart.
REQ-020 oReady = 1 only in ACC (combinational from state); a product is accepted when iValid and oReady are both 1 on a rising edge.
REQ-021 On each accept: sum <= sum + zero-extend(iProd); count <= count + 1.
REQ-022 The accept at which count = latched length - 1 is the final accept; at that edge the state goes to DONE.
REQ-023 oValid rises in the cycle after the final accept, with oAcc equal to the complete sum: 1-cycle latency.
REQ-024 The sum is unsigned and never overflows: ACCWIDTH covers (2^CNTWIDTH-1) products of maximum value; no saturation logic is required.
REQ-025 In DONE, oValid=1 and oAcc is held stable until iReady=1; on that edge the state goes to IDLE and oValid falls.
REQ-026 In IDLE, oAcc retains the last result; oValid=0.
REQ-027 iValid while not in ACC is ignored; the product is dropped and nothing changes.
REQ-028 A cycle in ACC with iValid=0 holds sum, count and state unchanged.
REQ-029 iClr=1 in any state, synchronously on the next edge: state goes to IDLE; sum, count, latched length and oAcc clear to 0; oValid goes to 0.
REQ-030 iClr takes priority over iStart, accept and iReady in the same cycle.
REQ-031 iStart in the same cycle that DONE is left via iReady is not accepted; a new burst requires iStart while in IDLE.

Reset
REQ-032 While iRst=1: state=IDLE, sum=0, count=0, latched length=0, oAcc=0, oValid=0, oReady=0, oBusy=0, regardless of the clock.
REQ-033 Reset asserted mid-burst aborts the burst; no partial result is presented after reset deasserts.
REQ-034 The first edge after iRst deasserts behaves as IDLE.

Verification
REQ-035 Basic burst: iLen=3, iProd = 10, 20, 30 on consecutive cycles with iValid=1 and iReady=1 -> oValid for 1 cycle the cycle after the third accept, oAcc=60, then IDLE.
REQ-036 Gaps and backpressure: iLen=2, iProd 100, (iValid=0 for 2 cycles), 200; iReady=0 for 3 cycles -> oAcc=300 held with oValid=1 for 4 cycles, then oValid=0.
REQ-037 Maximum width: iLen=255, every iProd=65025 -> oAcc=16581375 with no wrap.
REQ-038 Zero length: iStart with iLen=0 -> oValid=1 with oAcc=0 the next cycle; iProd is never accepted.
REQ-039 Clear and reset mid-burst: iLen=4, 2 accepts, then iClr=1 -> IDLE with oAcc=0; repeat with iRst pulsed -> all outputs 0 asynchronously; a following burst of iLen=1, iProd=7 gives oAcc=7.
REQ-040 Ignored inputs: iStart and iValid asserted in DONE -> no change to oAcc or state until iReady=1.
